multicycle_control_unit: RTL

Moore-style control FSM for the multicycle RV32I core subset (lw, sw, R-type, I-type ALU, beq, jal). It decodes the registered instruction fields and sequences the datapath one step per clock. It drives `immsrc` straight into `Extend_unit` and also drives the PC/IR/register-file/memory write strobes and the ALU operand, control and result selects.

---
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore control FSM for the multicycle RV32I subset (lw, sw, R-type,
//   I-type ALU, beq, jal). The FSM advances one datapath step per clock.
//   Ports:
//     clk, rst_n              clock and asynchronous active-low reset
//     op, funct3, funct7b5    decoded fields of the registered instruction
//     zero                    ALU zero flag, used only in BEQ
//     immsrc                  immediate format select for Extend_unit
//     alusrca, alusrcb        ALU operand selects
//     resultsrc, alucontrol   result select and ALU operation
//     adrsrc                  memory address select
//     irwrite, pcwrite        IR/OldPC and PC load strobes
//     regwrite, memwrite      register-file and data-memory write strobes
//     state_o                 current state code
module multicycle_control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [2:0] alucontrol,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic [3:0] state_o
);

  localparam int unsigned STATE_W = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] aluop_c;
  logic       branch_c;
  logic       pcupdate_c;
  logic       irwrite_c;
  logic       regwrite_c;
  logic       memwrite_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, per-state controls and ALU decode
  always_comb begin
    state_d    = S_FETCH;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    resultsrc  = 2'b00;
    adrsrc     = 1'b0;
    aluop_c    = 2'b00;
    branch_c   = 1'b0;
    pcupdate_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    memwrite_c = 1'b0;
    alucontrol = 3'b000;

    unique case (state_q)
      S_FETCH: begin
        state_d    = S_DECODE;
        alusrcb    = 2'b10;
        resultsrc  = 2'b10;
        irwrite_c  = 1'b1;
        pcupdate_c = 1'b1;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        // Unsupported opcodes fall back to FETCH, skipping the instruction
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        resultsrc  = 2'b01;
        regwrite_c = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite_c = 1'b1;
      end
      S_EXECR: begin
        state_d = S_ALUWB;
        alusrca = 2'b10;
        aluop_c = 2'b10;
      end
      S_EXECI: begin
        state_d = S_ALUWB;
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop_c = 2'b10;
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
      end
      S_BEQ: begin
        alusrca  = 2'b10;
        aluop_c  = 2'b01;
        branch_c = 1'b1;
      end
      S_JAL: begin
        state_d    = S_ALUWB;
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        pcupdate_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Subtract only for R-type sub; I-type addi ignores instr[30]
    case (aluop_c)
      2'b01:   alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    immsrc = 2'b00;
    case (op)
      OP_STORE: immsrc = 2'b01;
      OP_BEQ:   immsrc = 2'b10;
      OP_JAL:   immsrc = 2'b11;
      default:  immsrc = 2'b00;
    endcase
  end

  // Strobes are held low for the whole reset pulse, even though FETCH is showing
  assign irwrite  = rst_n & irwrite_c;
  assign pcwrite  = rst_n & (pcupdate_c | (branch_c & zero));
  assign regwrite = rst_n & regwrite_c;
  assign memwrite = rst_n & memwrite_c;
  assign state_o  = STATE_W'(state_q);

endmodule
